ex_stage: RTL
=============

Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS R2000 pipeline. Sits between the ID/EX decode outputs and the MEM stage, and registers its results into the EX/MEM boundary that MEM consumes (wb_MEM, m, zero, address_MEM, write_data_mem, reg_MEM).
- Contains the ALU, the destination-register mux and the branch-target adder.
- Contains an iterative 32-cycle HI/LO multiply/divide unit with a stall handshake back to the hazard logic.

Parameters:
- MD_CYCLES, 32, iterations per MULT/DIV; fixed radix-2, one bit per cycle.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous active-high reset
- wb_EX  in  2  writeback control from ID/EX
- m_EX  in  3  memory control from ID/EX: [2]=branch, [1]=mem read, [0]=mem write
- alu_op  in  4  ALU function code (see Behaviour)
- alu_src  in  1  0: operand B = read_data2; 1: operand B = imm_ext
- reg_dst  in  1  0: destination = rt; 1: destination = rd
- md_start  in  1  start a multiply/divide this cycle
- md_op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- read_data1  in  32  rs value
- read_data2  in  32  rt value
- imm_ext  in  32  sign-extended immediate
- pc_plus4  in  32  PC+4 of the instruction in EX
- rt  in  5  rt field
- rd  in  5  rd field
- wb_MEM  out  2  registered writeback control
- m  out  3  registered memory control
- zero  out  1  registered ALU-result-is-zero flag
- address_MEM  out  32  registered ALU result
- write_data_mem  out  32  registered read_data2
- reg_MEM  out  5  registered destination register
- branch_addr_MEM  out  32  registered pc_plus4 + (imm_ext << 2)
- md_busy  out  1  multiply/divide unit running
- ex_stall  out  1  combinational; instruction in EX must hold (upstream freezes PC, IF/ID and ID/EX)

Behaviour:
- Reset: every registered output is 0; HI = LO = 0; md_busy = 0; the iteration counter is 0.
- Reset mid-operation: aborts the multiply/divide and leaves HI = LO = 0.
- Operand A = read_data1. Operand B = alu_src ? imm_ext : read_data2.
- alu_op encoding:
  - 0000 AND, 0001 OR, 1001 XOR, 1010 NOR
  - 0010 ADD (wraps mod 2^32), 0110 SUB (wraps mod 2^32)
  - 0111 SLT (signed, result 0 or 1), 1000 SLTU (unsigned)
  - 1100 LUI: result = {B[15:0], 16'h0}
  - 1101 MFHI: result = HI; 1110 MFLO: result = LO
  - any other code: result = 0
- zero = (result == 0) for every opcode.
- Latency: 1 cycle. The EX/MEM register captures every cycle unless ex_stall is high.
- ex_stall = md_busy AND (md_start OR alu_op is MFHI OR alu_op is MFLO).
  - While stalled, the EX/MEM register loads a bubble: wb_MEM = 0 and m = 0; other fields don't-care (drive 0).
  - Instructions independent of HI/LO proceed while md_busy is high.
- md_start with md_busy = 0: latch operands (A = read_data1, B = read_data2) and md_op. md_busy goes high the next cycle for exactly MD_CYCLES cycles.
  - HI/LO update on the clock edge that ends the final iteration. md_busy falls on that same edge.
  - An MFHI/MFLO presented in the cycle right after md_busy falls sees the new HI/LO with no stall.
- MULT/MULTU: {HI,LO} = 64-bit signed/unsigned product.
- DIV/DIVU: LO = quotient, HI = remainder.
  - Signed: truncate toward zero; remainder takes the sign of the dividend.
  - Computed on magnitudes, with signs fixed after the last iteration.
- Divide by zero (either signedness): LO = 32'hFFFFFFFF, HI = dividend. Still takes MD_CYCLES cycles.
- DIV 32'h80000000 / -1: LO = 32'h80000000, HI = 0.
- md_start while md_busy: ignored by the unit, and the instruction stalls as above until accepted.

Optional Feature:
- Macro EX_OVERFLOW_EN.
- Defined:
  - Adds output ovf (out, 1, registered, reset 0).
  - On signed overflow of ADD or SUB: ovf = 1 for that instruction's EX/MEM cycle, and the EX/MEM register loads a bubble (wb_MEM = 0, m = 0), suppressing the write.
- Undefined: ovf port is absent; ADD and SUB wrap silently.

Test Plan:
- rst high 2 cycles, then ADD with A=5, B=imm 7, alu_src=1, reg_dst=0, rt=9 -> next cycle address_MEM=12, zero=0, reg_MEM=9, wb_MEM and m equal their inputs.
- SUB with A=B=32'h1234, m_EX=3'b100, imm_ext=4, pc_plus4=32'h100 -> zero=1, branch_addr_MEM=32'h110, m=3'b100.
- MULT with A=-3, B=7; then MFLO held on the inputs -> ex_stall high for 32 cycles with bubbles on wb_MEM/m; then address_MEM=32'hFFFFFFEB; MFHI yields 32'hFFFFFFFF.
- DIVU with A=100, B=0, then DIV with A=-7, B=2 -> first gives LO=32'hFFFFFFFF, HI=100; second gives LO=-3, HI=-1. Independent ORs issued during each run are not stalled.
- MULT started, rst asserted at iteration 10 -> md_busy=0 and all outputs 0 next cycle; a following MFHI returns 0 with no stall.
- EX_OVERFLOW_EN: ADD with A=32'h7FFFFFFF, B=1 -> ovf=1, wb_MEM=0, m=0; ADD with A=1, B=1 -> ovf=0.

Source files
------------

// File: rtl/ex_stage.sv
// MIPS R2000 execute stage: ALU, destination mux, branch adder, EX/MEM register and 32-cycle HI/LO mul/div unit.
// Define EX_OVERFLOW_EN to add the ovf output and squash ADD/SUB results that overflow (signed).
module ex_stage #(
    parameter int MD_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  wb_EX,
    input  logic [2:0]  m_EX,
    input  logic [3:0]  alu_op,
    input  logic        alu_src,
    input  logic        reg_dst,
    input  logic        md_start,
    input  logic [1:0]  md_op,
    input  logic [31:0] read_data1,
    input  logic [31:0] read_data2,
    input  logic [31:0] imm_ext,
    input  logic [31:0] pc_plus4,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    output logic [1:0]  wb_MEM,
    output logic [2:0]  m,
    output logic        zero,
    output logic [31:0] address_MEM,
    output logic [31:0] write_data_mem,
    output logic [4:0]  reg_MEM,
    output logic [31:0] branch_addr_MEM,
`ifdef EX_OVERFLOW_EN
    output logic        ovf,
`endif
    output logic        md_busy,
    output logic        ex_stall
);

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b1000;
    localparam logic [3:0] ALU_XOR  = 4'b1001;
    localparam logic [3:0] ALU_NOR  = 4'b1010;
    localparam logic [3:0] ALU_LUI  = 4'b1100;
    localparam logic [3:0] ALU_MFHI = 4'b1101;
    localparam logic [3:0] ALU_MFLO = 4'b1110;

    localparam int CNT_W = $clog2(MD_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_CYCLES - 1);

    logic [31:0]      op_b_s, sum_s, diff_s, result_s;
    logic             trap_s, md_accept_s;
    logic [31:0]      hi_r, lo_r;
    logic             busy_r;
    logic [CNT_W-1:0] cnt_r;
    logic [1:0]       mop_r;
    logic [31:0]      a_r, b_r, acc_r, q_r, mcand_r;
    logic [32:0]      mul_sum_s, div_sh_s, div_diff_s;
    logic [31:0]      acc_nx_s, q_nx_s, hi_fin_s, lo_fin_s;
    logic [63:0]      prod_s;
    logic             neg_a_s, neg_b_s;

    function automatic logic [31:0] magnitude(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (32'd0 - v) : v;
    endfunction

    // ALU: operand select and result mux
    always_comb begin
        op_b_s   = alu_src ? imm_ext : read_data2;
        sum_s    = read_data1 + op_b_s;
        diff_s   = read_data1 - op_b_s;
        result_s = 32'd0;
        case (alu_op)
            ALU_AND:  result_s = read_data1 & op_b_s;
            ALU_OR:   result_s = read_data1 | op_b_s;
            ALU_XOR:  result_s = read_data1 ^ op_b_s;
            ALU_NOR:  result_s = ~(read_data1 | op_b_s);
            ALU_ADD:  result_s = sum_s;
            ALU_SUB:  result_s = diff_s;
            ALU_SLT:  result_s = {31'd0, ($signed(read_data1) < $signed(op_b_s))};
            ALU_SLTU: result_s = {31'd0, (read_data1 < op_b_s)};
            ALU_LUI:  result_s = {op_b_s[15:0], 16'h0000};
            ALU_MFHI: result_s = hi_r;
            ALU_MFLO: result_s = lo_r;
            default:  result_s = 32'd0;
        endcase
    end

`ifdef EX_OVERFLOW_EN
    // Signed overflow detection for ADD/SUB
    always_comb begin
        if (alu_op == ALU_ADD) begin
            trap_s = (read_data1[31] == op_b_s[31]) && (sum_s[31] != read_data1[31]);
        end else if (alu_op == ALU_SUB) begin
            trap_s = (read_data1[31] != op_b_s[31]) && (diff_s[31] != read_data1[31]);
        end else begin
            trap_s = 1'b0;
        end
    end
`else
    assign trap_s = 1'b0;
`endif

    assign md_accept_s = md_start & ~busy_r;
    assign md_busy     = busy_r;
    assign ex_stall    = busy_r & (md_start | (alu_op == ALU_MFHI) | (alu_op == ALU_MFLO));

    // One radix-2 iteration: shift-add multiply or restoring divide on magnitudes
    always_comb begin
        mul_sum_s  = {1'b0, acc_r} + {1'b0, (q_r[0] ? mcand_r : 32'd0)};
        div_sh_s   = {acc_r, q_r[31]};
        div_diff_s = div_sh_s - {1'b0, mcand_r};
        if (mop_r[1]) begin
            if (!div_diff_s[32]) begin
                acc_nx_s = div_diff_s[31:0];
                q_nx_s   = {q_r[30:0], 1'b1};
            end else begin
                acc_nx_s = div_sh_s[31:0];
                q_nx_s   = {q_r[30:0], 1'b0};
            end
        end else begin
            acc_nx_s = mul_sum_s[32:1];
            q_nx_s   = {mul_sum_s[0], q_r[31:1]};
        end
    end

    // Sign fix-up applied to the final iteration's result
    always_comb begin
        neg_a_s = ~mop_r[0] & a_r[31];
        neg_b_s = ~mop_r[0] & b_r[31];
        prod_s  = {acc_nx_s, q_nx_s};
        if (mop_r[1]) begin
            if (b_r == 32'd0) begin
                hi_fin_s = a_r;
                lo_fin_s = 32'hFFFF_FFFF;
            end else begin
                hi_fin_s = neg_a_s ? (32'd0 - acc_nx_s) : acc_nx_s;
                lo_fin_s = (neg_a_s ^ neg_b_s) ? (32'd0 - q_nx_s) : q_nx_s;
            end
        end else begin
            if (neg_a_s ^ neg_b_s) begin
                prod_s = 64'd0 - prod_s;
            end else begin
                prod_s = prod_s;
            end
            hi_fin_s = prod_s[63:32];
            lo_fin_s = prod_s[31:0];
        end
    end

    // Multiply/divide sequencer and HI/LO registers
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r  <= 1'b0;
            cnt_r   <= '0;
            mop_r   <= 2'b00;
            a_r     <= 32'd0;
            b_r     <= 32'd0;
            acc_r   <= 32'd0;
            q_r     <= 32'd0;
            mcand_r <= 32'd0;
            hi_r    <= 32'd0;
            lo_r    <= 32'd0;
        end else if (md_accept_s) begin
            busy_r  <= 1'b1;
            cnt_r   <= '0;
            mop_r   <= md_op;
            a_r     <= read_data1;
            b_r     <= read_data2;
            acc_r   <= 32'd0;
            q_r     <= magnitude(read_data1, ~md_op[0]);
            mcand_r <= magnitude(read_data2, ~md_op[0]);
        end else if (busy_r) begin
            acc_r <= acc_nx_s;
            q_r   <= q_nx_s;
            cnt_r <= cnt_r + CNT_W'(1);
            if (cnt_r == CNT_LAST) begin
                busy_r <= 1'b0;
                cnt_r  <= '0;
                hi_r   <= hi_fin_s;
                lo_r   <= lo_fin_s;
            end
        end
    end

    // EX/MEM pipeline register; a stall or overflow trap inserts a bubble
    always_ff @(posedge clk) begin
        if (rst || ex_stall) begin
            wb_MEM          <= 2'b00;
            m               <= 3'b000;
            zero            <= 1'b0;
            address_MEM     <= 32'd0;
            write_data_mem  <= 32'd0;
            reg_MEM         <= 5'd0;
            branch_addr_MEM <= 32'd0;
`ifdef EX_OVERFLOW_EN
            ovf             <= 1'b0;
`endif
        end else begin
            wb_MEM          <= trap_s ? 2'b00 : wb_EX;
            m               <= trap_s ? 3'b000 : m_EX;
            zero            <= (result_s == 32'd0);
            address_MEM     <= result_s;
            write_data_mem  <= read_data2;
            reg_MEM         <= reg_dst ? rd : rt;
            branch_addr_MEM <= pc_plus4 + {imm_ext[29:0], 2'b00};
`ifdef EX_OVERFLOW_EN
            ovf             <= trap_s;
`endif
        end
    end

endmodule
